// File: rtl/mua_pkg.sv
// Shared constants and types for the mua_comb bank packer: lane geometry,
// derived widths and the packer FSM state type.
package mua_pkg;

   localparam int NUM_BANK    = 5;
   localparam int CH_PER_BANK = 32;
   localparam int DW          = 32;
   localparam int CHW         = 12;

   localparam int TOTAL_CH = NUM_BANK * CH_PER_BANK;
   localparam int SLOT_W   = $clog2(CH_PER_BANK);
   localparam int LANE_W   = CHW - SLOT_W;
   localparam int LIDX_W   = $clog2(NUM_BANK);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } pack_state_t;

   // Channel number carried by a lane at a given slot; CH_PER_BANK is a power of 2.
   function automatic logic [CHW-1:0] lane_ch(input int lane, input logic [SLOT_W-1:0] slot);
      return CHW'(lane * CH_PER_BANK) | CHW'(slot);
   endfunction

endpackage

// File: rtl/mua_lane_ram.sv
// Simple dual-port lane RAM holding both ping-pong buffers; address is {buf_sel, slot}.
// One write port, one read port with a single registered read cycle; contents are not reset.
module mua_lane_ram #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mua_bank_packer.sv
// Packs the serial per-channel FIR stream into NUM_BANK ping-pong lane RAMs and drains each frame
// as CH_PER_BANK beats on the mua_comb bus. Optional MUA_PACK_VALID_MASK_EN adds per-entry written bits and miss_err.
module mua_bank_packer
   import mua_pkg::*;
(
   input  logic                     bus_clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     s_valid,
   input  logic [CHW-1:0]           s_ch,
   input  logic [DW-1:0]            s_data,
   input  logic                     s_eof,
   output logic                     mua_comb_valid,
   output logic [NUM_BANK*CHW-1:0]  mua_comb_ch,
   output logic [NUM_BANK*DW-1:0]   mua_comb_data,
   output logic                     busy,
   output logic                     overrun,
   output logic                     ch_err,
`ifdef MUA_PACK_VALID_MASK_EN
   output logic                     miss_err,
`endif
   output pack_state_t              state
);

   // Input handshake: a sample is taken on any cycle with en & s_valid (no backpressure);
   // s_eof is only meaningful on such a cycle.
   logic              accept;
   logic              ch_bad;
   logic [SLOT_W-1:0] wr_slot;
   logic [LANE_W-1:0] wr_lane;
   logic              wsel;
   logic              rsel;
   logic [SLOT_W-1:0] slot;
   logic [SLOT_W-1:0] out_slot;

   assign accept  = en & s_valid;
   assign ch_bad  = (s_ch >= CHW'(TOTAL_CH));
   assign wr_slot = s_ch[SLOT_W-1:0];
   assign wr_lane = s_ch[CHW-1:SLOT_W];
   assign busy    = (state == DRAIN) | mua_comb_valid;

   always_ff @(posedge bus_clk) begin
      if (rst) begin
         state          <= IDLE;
         wsel           <= 1'b0;
         rsel           <= 1'b0;
         slot           <= '0;
         out_slot       <= '0;
         mua_comb_valid <= 1'b0;
         overrun        <= 1'b0;
         ch_err         <= 1'b0;
      end else begin
         mua_comb_valid <= (state == DRAIN);
         out_slot       <= slot;
         if (accept & ch_bad) begin
            ch_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept & s_eof) begin
                  rsel  <= wsel;
                  wsel  <= ~wsel;
                  slot  <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // A frame ending while draining is dropped; its data stays in wsel to be overwritten.
               if (accept & s_eof) begin
                  overrun <= 1'b1;
               end
               if (slot == SLOT_W'(CH_PER_BANK - 1)) begin
                  slot  <= '0;
                  state <= IDLE;
               end else begin
                  slot <= slot + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUA_PACK_VALID_MASK_EN
   // written bits never collide on set/clear: writes target wsel while drains read rsel != wsel.
   logic [1:0][NUM_BANK-1:0][CH_PER_BANK-1:0] written;
   logic [NUM_BANK-1:0]                       miss_q;

   always_ff @(posedge bus_clk) begin
      if (rst) begin
         written  <= '0;
         miss_q   <= '0;
         miss_err <= 1'b0;
      end else begin
         if (accept & ~ch_bad) begin
            written[wsel][wr_lane[LIDX_W-1:0]][wr_slot] <= 1'b1;
         end
         for (int k = 0; k < NUM_BANK; k++) begin
            if (state == DRAIN) begin
               miss_q[k]                <= ~written[rsel][k][slot];
               written[rsel][k][slot]   <= 1'b0;
               if (~written[rsel][k][slot]) begin
                  miss_err <= 1'b1;
               end
            end else begin
               miss_q[k] <= 1'b0;
            end
         end
      end
   end
`endif

   for (genvar k = 0; k < NUM_BANK; k++) begin : g_lane
      logic          we;
      logic [DW-1:0] rdata;

      assign we = accept & ~ch_bad & (wr_lane == LANE_W'(k));

      mua_lane_ram #(
         .DW (DW),
         .AW (SLOT_W + 1)
      ) u_ram (
         .clk   (bus_clk),
         .we    (we),
         .waddr ({wsel, wr_slot}),
         .wdata (s_data),
         .raddr ({rsel, slot}),
         .rdata (rdata)
      );

      assign mua_comb_ch[k*CHW +: CHW] = mua_comb_valid ? lane_ch(k, out_slot) : '0;
`ifdef MUA_PACK_VALID_MASK_EN
      assign mua_comb_data[k*DW +: DW] = (mua_comb_valid & ~miss_q[k]) ? rdata : '0;
`else
      assign mua_comb_data[k*DW +: DW] = mua_comb_valid ? rdata : '0;
`endif
   end

endmodule

// File: tb/tb_mua_bank_packer.sv
// Randomised bench for mua_bank_packer against a channel-indexed frame model with cycle-stamped beats.
// Covers MUA_PACK_VALID_MASK_EN when that macro is defined for the build.
module tb_mua_bank_packer;
   import mua_pkg::*;

   localparam int CW = NUM_BANK * DW;

   logic                    bus_clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    en = 1'b0;
   logic                    s_valid = 1'b0;
   logic [CHW-1:0]          s_ch = '0;
   logic [DW-1:0]           s_data = '0;
   logic                    s_eof = 1'b0;
   logic                    mua_comb_valid;
   logic [NUM_BANK*CHW-1:0] mua_comb_ch;
   logic [NUM_BANK*DW-1:0]  mua_comb_data;
   logic                    busy;
   logic                    overrun;
   logic                    ch_err;
`ifdef MUA_PACK_VALID_MASK_EN
   logic                    miss_err;
`endif
   pack_state_t             state_dbg;

   mua_bank_packer dut (
      .bus_clk        (bus_clk),
      .rst            (rst),
      .en             (en),
      .s_valid        (s_valid),
      .s_ch           (s_ch),
      .s_data         (s_data),
      .s_eof          (s_eof),
      .mua_comb_valid (mua_comb_valid),
      .mua_comb_ch    (mua_comb_ch),
      .mua_comb_data  (mua_comb_data),
      .busy           (busy),
      .overrun        (overrun),
      .ch_err         (ch_err),
`ifdef MUA_PACK_VALID_MASK_EN
      .miss_err       (miss_err),
`endif
      .state          (state_dbg)
   );

   always #5 bus_clk = ~bus_clk;

   int cyc = 0;
   always @(posedge bus_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int                      cyc;
      logic [NUM_BANK*CHW-1:0] ch;
      logic [NUM_BANK*DW-1:0]  data;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] mbuf [2][TOTAL_CH];
   bit            mwr  [2][TOTAL_CH];
   bit            m_wsel = 1'b0;
   bit            m_overrun = 1'b0;
   bit            m_ch_err = 1'b0;
   bit            m_miss = 1'b0;
   int            ds = -1000;
   int            drain_end = -1000;
   int            busy_end = -1000;

   task automatic model_accept(input int ch, input logic [DW-1:0] d, input bit eof, input int t);
      beat_t b;
      int    c;
      if (ch >= TOTAL_CH) m_ch_err = 1'b1;
      else begin
         mbuf[m_wsel][ch] = d;
         mwr[m_wsel][ch]  = 1'b1;
      end
      if (eof) begin
         if (t >= ds && t <= drain_end) m_overrun = 1'b1;
         else begin
            ds        = t + 1;
            drain_end = t + CH_PER_BANK;
            busy_end  = t + CH_PER_BANK + 1;
            for (int s = 0; s < CH_PER_BANK; s++) begin
               b.cyc = t + 2 + s;
               for (int k = 0; k < NUM_BANK; k++) begin
                  c = k * CH_PER_BANK + s;
                  b.ch[k*CHW +: CHW] = CHW'(c);
`ifdef MUA_PACK_VALID_MASK_EN
                  b.data[k*DW +: DW] = mwr[m_wsel][c] ? mbuf[m_wsel][c] : '0;
                  if (!mwr[m_wsel][c]) m_miss = 1'b1;
                  mwr[m_wsel][c] = 1'b0;
`else
                  b.data[k*DW +: DW] = mbuf[m_wsel][c];
`endif
               end
               exp_q.push_back(b);
            end
            m_wsel = ~m_wsel;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit e, input bit v, input int ch, input logic [DW-1:0] d, input bit eof);
      @(posedge bus_clk);
      #1;
      en      = e;
      s_valid = v;
      s_ch    = CHW'(ch);
      s_data  = d;
      s_eof   = eof;
      if (e && v) model_accept(ch, d, eof, cyc);
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, 0, '0, 1'b0);
   endtask

   // mode 0: data=ch*3, 1: data=ch+1000, 2: random; skip_ch is left out of the frame
   task automatic full_frame(input int mode, input int skip_ch);
      logic [DW-1:0] d;
      for (int ch = 0; ch < TOTAL_CH; ch++) begin
         d = (mode == 0) ? DW'(ch * 3) : (mode == 1) ? DW'(ch + 1000) : DW'($urandom);
         if (ch != skip_ch) drive(1'b1, 1'b1, ch, d, ch == TOTAL_CH - 1);
         else if (ch == TOTAL_CH - 1) drive(1'b1, 1'b1, TOTAL_CH, d, 1'b1);
      end
      idle_cycle();
   endtask

   task automatic do_reset(input int n);
      @(posedge bus_clk);
      #1;
      rst     = 1'b1;
      en      = 1'b0;
      s_valid = 1'b0;
      s_eof   = 1'b0;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
      if (drain_end > cyc) drain_end = cyc;
      if (busy_end > cyc) busy_end = cyc;
      m_wsel = 1'b0; m_overrun = 1'b0; m_ch_err = 1'b0; m_miss = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int c = 0; c < TOTAL_CH; c++) mwr[b][c] = 1'b0;
      repeat (n) @(posedge bus_clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      idle_cycle();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         @(posedge bus_clk);
         #1;
      end
      check("idle_reached", CW'(exp_q.size() == 0 && !busy), CW'(1));
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_overrun"}, CW'(overrun), CW'(m_overrun));
      check({tag, "_ch_err"}, CW'(ch_err), CW'(m_ch_err));
`ifdef MUA_PACK_VALID_MASK_EN
      check({tag, "_miss_err"}, CW'(miss_err), CW'(m_miss));
`endif
   endtask

   // ---------------- scoreboard / monitor ----------------
   bit    mon_on = 1'b0;
   bit    mon_due;
   beat_t mon_b;

   always @(negedge bus_clk) begin
      if (mon_on) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_b = exp_q.pop_front();
            check("beat_cycle", CW'(cyc), CW'(mon_b.cyc));
         end
         mon_due = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
         check("valid", CW'(mua_comb_valid), CW'(mon_due));
         check("busy", CW'(busy), CW'(cyc >= ds && cyc <= busy_end));
         if (mon_due) begin
            mon_b = exp_q.pop_front();
            check("beat_ch", CW'(mua_comb_ch), CW'(mon_b.ch));
            check("beat_data", CW'(mua_comb_data), CW'(mon_b.data));
         end else begin
            check("idle_ch", CW'(mua_comb_ch), '0);
            check("idle_data", CW'(mua_comb_data), '0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t_eof;
      int n, ch;
      bit e, v;

      repeat (3) @(posedge bus_clk);
      #1;
      rst = 1'b0;
      @(negedge bus_clk);
      check("rst_valid", CW'(mua_comb_valid), '0);
      check("rst_ch", CW'(mua_comb_ch), '0);
      check("rst_data", CW'(mua_comb_data), '0);
      check("rst_busy", CW'(busy), '0);
      check("rst_state", CW'(state_dbg), CW'(IDLE));
      check_flags("rst");
      mon_on = 1'b1;

      // 1: single frame, data = ch*3
      full_frame(0, -1);
      wait_idle();
      check_flags("t1");

      // 2: back-to-back frames
      full_frame(0, -1);
      full_frame(1, -1);
      wait_idle();
      check_flags("t2");

      // 3: out-of-range channel, then a clean frame
      drive(1'b1, 1'b1, TOTAL_CH, 32'd7, 1'b0);
      full_frame(2, -1);
      wait_idle();
      check_flags("t3");

      // 4: two short frames 10 cycles apart
      drive(1'b1, 1'b1, 3, DW'($urandom), 1'b0);
      drive(1'b1, 1'b1, 40, DW'($urandom), 1'b1);
      repeat (9) idle_cycle();
      drive(1'b1, 1'b1, 5, DW'($urandom), 1'b1);
      wait_idle();
      check_flags("t4");

      // 5: reset at drain beat 10, then a fresh frame
      full_frame(2, -1);
      t_eof = cyc - 1;
      while (cyc < t_eof + 11) idle_cycle();
      do_reset(2);
      @(negedge bus_clk);
      check("t5_state", CW'(state_dbg), CW'(IDLE));
      full_frame(2, -1);
      wait_idle();
      check_flags("t5");

`ifdef MUA_PACK_VALID_MASK_EN
      // 6: frame missing ch 37
      full_frame(2, -1);
      full_frame(2, 37);
      wait_idle();
      check_flags("t6");
`endif

      // random frames: partial/duplicate channels, bad channels, en/valid gaps, early eofs
      for (int f = 0; f < 25; f++) begin
         n = $urandom_range(1, 190);
         for (int i = 0; i < n; i++) begin
            ch = ($urandom_range(0, 29) == 0) ? $urandom_range(TOTAL_CH, 4095) : $urandom_range(0, TOTAL_CH - 1);
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 9) != 0);
            drive(e, v, ch, DW'($urandom), i == n - 1);
         end
         repeat ($urandom_range(0, 40)) idle_cycle();
         if (f % 5 == 4) begin
            wait_idle();
            check_flags("rnd");
         end
      end
      wait_idle();
      check_flags("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
